// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states and the
// instruction-width derivation.
package acc_cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_JMP  = 3'b100,
        OP_JZ   = 3'b101,
        OP_OUT  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    function automatic int instr_width(input int data_w);
        return OPCODE_W + data_w;
    endfunction

endpackage

// File: rtl/acc_cpu_imem.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Deliberately unreset so a loaded program survives reset.
module acc_cpu_imem
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [instr_width(DATA_W)-1:0]   wr_data,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [instr_width(DATA_W)-1:0]   rd_data
);

    localparam int INSTR_W = instr_width(DATA_W);
    localparam int DEPTH   = 1 << ADDR_W;

    logic [INSTR_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/acc_cpu.sv
// Two-cycle-per-instruction accumulator CPU (FETCH/EXEC) with a
// ready/valid OUT port and a loadable program memory.
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             prog_we,
    input  logic [ADDR_W-1:0]                prog_addr,
    input  logic [instr_width(DATA_W)-1:0]   prog_data,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                acc,
    output logic [ADDR_W-1:0]                pc,
    output logic                             zero,
    output logic                             carry,
    output logic                             busy,
    output logic                             halted
);

    localparam int INSTR_W = instr_width(DATA_W);

    // Reset asserts asynchronously but releases only after two clock edges.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    state_e              state, state_nxt;
    logic [INSTR_W-1:0]  ir, ir_nxt;
    logic [INSTR_W-1:0]  mem_rd;
    logic [DATA_W-1:0]   acc_nxt, out_hold, out_hold_nxt;
    logic [ADDR_W-1:0]   pc_nxt, pc_inc;
    logic                zero_nxt, carry_nxt;
    logic                mem_we;
    opcode_e             op;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W:0]     sum, diff;

    assign op     = opcode_e'(ir[INSTR_W-1 -: OPCODE_W]);
    assign imm    = ir[DATA_W-1:0];
    assign sum    = {1'b0, acc} + {1'b0, imm};
    assign diff   = {1'b0, acc} - {1'b0, imm};
    assign pc_inc = pc + 1'b1;
    assign mem_we = prog_we && (state == S_IDLE || state == S_HALT);

    acc_cpu_imem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc),
        .rd_data (mem_rd)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= S_IDLE;
            ir       <= '0;
            acc      <= '0;
            pc       <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            out_hold <= '0;
        end else begin
            state    <= state_nxt;
            ir       <= ir_nxt;
            acc      <= acc_nxt;
            pc       <= pc_nxt;
            zero     <= zero_nxt;
            carry    <= carry_nxt;
            out_hold <= out_hold_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ir_nxt       = ir;
        acc_nxt      = acc;
        pc_nxt       = pc;
        zero_nxt     = zero;
        carry_nxt    = carry;
        out_hold_nxt = out_hold;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                    acc_nxt   = '0;
                    zero_nxt  = 1'b0;
                    carry_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                ir_nxt    = mem_rd;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
                case (op)
                    OP_LOAD: begin
                        acc_nxt  = imm;
                        zero_nxt = (imm == '0);
                    end
                    OP_ADD: begin
                        acc_nxt   = sum[DATA_W-1:0];
                        zero_nxt  = (sum[DATA_W-1:0] == '0);
                        carry_nxt = sum[DATA_W];
                    end
                    OP_SUB: begin
                        // The extra top bit of the widened difference is the borrow.
                        acc_nxt   = diff[DATA_W-1:0];
                        zero_nxt  = (diff[DATA_W-1:0] == '0);
                        carry_nxt = diff[DATA_W];
                    end
                    OP_JMP: begin
                        pc_nxt = imm[ADDR_W-1:0];
                    end
                    OP_JZ: begin
                        if (zero) begin
                            pc_nxt = imm[ADDR_W-1:0];
                        end
                    end
                    OP_OUT: begin
                        if (out_ready) begin
                            out_hold_nxt = acc;
                        end else begin
                            state_nxt = S_EXEC;
                            pc_nxt    = pc;
                        end
                    end
                    OP_HALT: begin
                        state_nxt = S_HALT;
                        pc_nxt    = pc;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = (state == S_FETCH) || (state == S_EXEC);
    assign halted    = (state == S_HALT);
    assign out_valid = (state == S_EXEC) && (op == OP_OUT);
    assign out_data  = out_valid ? acc : out_hold;

endmodule

// File: tb/tb_acc_cpu.sv
// Directed bench for acc_cpu at DATA_W=8, ADDR_W=4.
module tb_acc_cpu;
    import acc_cpu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [10:0] prog_data;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [7:0]  acc;
    logic [3:0]  pc;
    logic        zero;
    logic        carry;
    logic        busy;
    logic        halted;

    int total = 0;
    int bad   = 0;

    acc_cpu #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .acc       (acc),
        .pc        (pc),
        .zero      (zero),
        .carry     (carry),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ins(input opcode_e op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    task automatic load_word(input logic [3:0] a, input logic [10:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs from start to HALT, counting cycles and OUT transfers.
    task automatic run_to_halt(output int n, output int nv, output logic [7:0] od);
        n  = 0;
        nv = 0;
        od = 8'h00;
        pulse_start();
        while (!halted && n < 200) begin
            if (out_valid && out_ready) begin
                nv++;
                od = out_data;
            end
            tick();
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    int          n, nv, vc;
    logic [7:0]  od;
    logic        flag_ok;

    initial begin
        reset_n   = 1'b1;
        start     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 11'd0;
        out_ready = 1'b1;
        #2 reset_n = 1'b0;
        tick();
        tick();
        check("rst_acc",    32'(acc),       32'd0);
        check("rst_pc",     32'(pc),        32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_halted", 32'(halted),    32'd0);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_flags",  32'({zero, carry}), 32'd0);
        reset_n = 1'b1;
        tick(); tick(); tick();

        // LOAD 5, ADD 3, OUT, HALT
        load_word(4'd0, ins(OP_LOAD, 8'd5));
        load_word(4'd1, ins(OP_ADD,  8'd3));
        load_word(4'd2, ins(OP_OUT,  8'd0));
        load_word(4'd3, ins(OP_HALT, 8'd0));
        for (int i = 4; i < 16; i++) load_word(4'(i), ins(OP_NOP, 8'd0));
        out_ready = 1'b1;
        run_to_halt(n, nv, od);
        check("a_cycles", 32'(n),        32'd8);
        check("a_nvalid", 32'(nv),       32'd1);
        check("a_odata",  32'(od),       32'd8);
        check("a_acc",    32'(acc),      32'd8);
        check("a_pc",     32'(pc),       32'd3);
        check("a_hold",   32'(out_data), 32'd8);

        // LOAD FF, ADD 1, HALT
        load_word(4'd0, ins(OP_LOAD, 8'hFF));
        load_word(4'd1, ins(OP_ADD,  8'd1));
        load_word(4'd2, ins(OP_HALT, 8'd0));
        run_to_halt(n, nv, od);
        check("add_wrap_acc",   32'(acc),   32'h00);
        check("add_wrap_zero",  32'(zero),  32'd1);
        check("add_wrap_carry", 32'(carry), 32'd1);

        // LOAD 0, SUB 1 -> borrow
        load_word(4'd0, ins(OP_LOAD, 8'h00));
        load_word(4'd1, ins(OP_SUB,  8'd1));
        run_to_halt(n, nv, od);
        check("sub_brw_acc",   32'(acc),   32'hFF);
        check("sub_brw_carry", 32'(carry), 32'd1);
        check("sub_brw_zero",  32'(zero),  32'd0);

        // Countdown loop: LOAD 3, SUB 1, JZ 4, JMP 1, HALT
        load_word(4'd0, ins(OP_LOAD, 8'd3));
        load_word(4'd1, ins(OP_SUB,  8'd1));
        load_word(4'd2, ins(OP_JZ,   8'd4));
        load_word(4'd3, ins(OP_JMP,  8'd1));
        load_word(4'd4, ins(OP_HALT, 8'd0));
        run_to_halt(n, nv, od);
        check("loop_cycles", 32'(n),     32'd20);
        check("loop_acc",    32'(acc),   32'd0);
        check("loop_zero",   32'(zero),  32'd1);
        check("loop_carry",  32'(carry), 32'd0);
        check("loop_pc",     32'(pc),    32'd4);

        // Stalled OUT: LOAD 5A, OUT, HALT with out_ready low for 5 cycles
        load_word(4'd0, ins(OP_LOAD, 8'h5A));
        load_word(4'd1, ins(OP_OUT,  8'd0));
        load_word(4'd2, ins(OP_HALT, 8'd0));
        out_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("stall_reach_out", 32'(out_valid), 32'd1);
        vc = 0;
        flag_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) vc++;
            if (out_data !== 8'h5A || pc !== 4'd1) flag_ok = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        if (out_valid) vc++;
        if (out_data !== 8'h5A || pc !== 4'd1) flag_ok = 1'b0;
        check("stall_valid_cycles", 32'(vc),      32'd6);
        check("stall_frozen",       32'(flag_ok), 32'd1);
        tick();
        check("stall_valid_drop", 32'(out_valid), 32'd0);
        check("stall_pc_adv",     32'(pc),        32'd2);
        check("stall_data_hold",  32'(out_data),  32'h5A);
        tick(); tick();
        check("stall_halted", 32'(halted), 32'd1);

        // All-NOP program: pc walks 0..15 and wraps; write while busy is ignored
        for (int i = 0; i < 16; i++) load_word(4'(i), ins(OP_NOP, 8'd0));
        pulse_start();
        check("nop_pc0", 32'(pc), 32'd0);
        load_word(4'd5, ins(OP_HALT, 8'd0));
        tick();
        flag_ok = 1'b1;
        for (int i = 1; i < 16; i++) begin
            if (pc !== 4'(i) || busy !== 1'b1 || halted !== 1'b0) flag_ok = 1'b0;
            tick();
            if (busy !== 1'b1 || halted !== 1'b0) flag_ok = 1'b0;
            tick();
        end
        check("nop_walk",   32'(flag_ok), 32'd1);
        check("nop_wrap",   32'(pc),      32'd0);
        check("nop_busy",   32'(busy),    32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();

        // Reset during stalled OUT, then restart without reloading
        load_word(4'd0, ins(OP_LOAD, 8'd5));
        load_word(4'd1, ins(OP_ADD,  8'd3));
        load_word(4'd2, ins(OP_OUT,  8'd0));
        load_word(4'd3, ins(OP_HALT, 8'd0));
        out_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        tick(); tick();
        check("rs_stalled", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rs_valid",  32'(out_valid), 32'd0);
        check("rs_data",   32'(out_data),  32'd0);
        check("rs_acc",    32'(acc),       32'd0);
        check("rs_pc",     32'(pc),        32'd0);
        check("rs_busy",   32'(busy),      32'd0);
        check("rs_halted", 32'(halted),    32'd0);
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b1;
        run_to_halt(n, nv, od);
        check("rs_cycles", 32'(n),   32'd8);
        check("rs_nvalid", 32'(nv),  32'd1);
        check("rs_odata",  32'(od),  32'd8);
        check("rs_acc_end", 32'(acc), 32'd8);
        check("rs_pc_end",  32'(pc),  32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
